// File: rtl/updown_count_monitor_pkg.sv
// Shared types and defaults for the up/down count monitor and its step classifier.
// Latency: n/a (types only). Backpressure: n/a.
package updown_mon_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } mon_state_t;

    typedef enum logic [1:0] {
        STEP_UP   = 2'd0,
        STEP_DN   = 2'd1,
        STEP_HOLD = 2'd2,
        STEP_BAD  = 2'd3
    } step_t;

    localparam int DEF_WIDTH    = 4;
    localparam int DEF_LOCK_CNT = 3;
    localparam int DEF_ERR_W    = 8;

endpackage

// File: rtl/updown_count_monitor_if.sv
// Sample bus from the observed counter plus the monitor's status outputs.
// Latency: n/a (wiring only). Backpressure: none, the monitor always accepts samples.
interface updown_count_monitor_if #(
    parameter int WIDTH = 4,
    parameter int ERR_W = 8
);
    logic             sample_en;
    logic [WIDTH-1:0] q_in;
    logic             dir;
    logic             locked;
    logic             hold;
    logic             wrap;
    logic             step_err;
    logic [ERR_W-1:0] err_count;

    modport master (
        output sample_en, q_in,
        input  dir, locked, hold, wrap, step_err, err_count
    );

    modport slave (
        input  sample_en, q_in,
        output dir, locked, hold, wrap, step_err, err_count
    );
endinterface

// File: rtl/updown_count_monitor_classify.sv
// Classifies one count step (prev -> cur) as up/down/hold/bad and flags max<->0 wraps.
// Latency: combinational. Backpressure: none.
module count_step_classify
    import updown_mon_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] prev,
    input  logic [WIDTH-1:0] cur,
    output step_t            step,
    output logic             wrap
);
    logic [WIDTH-1:0] d;

    always_comb begin
        d    = cur - prev;
        step = STEP_BAD;
        wrap = 1'b0;
        if (d == WIDTH'(1)) begin
            step = STEP_UP;
            wrap = (prev == '1);
        end else if (d == '1) begin
            step = STEP_DN;
            wrap = (prev == '0);
        end else if (d == '0) begin
            step = STEP_HOLD;
        end
    end
endmodule

// File: rtl/updown_count_monitor.sv
// Recovers count direction from a sampled up/down counter, locks on consistent steps, flags wraps/illegal jumps.
// Latency: 1 cycle, all outputs registered. Backpressure: none, every sample_en cycle is consumed.
module updown_count_monitor
    import updown_mon_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int LOCK_CNT = DEF_LOCK_CNT,
    parameter int ERR_W    = DEF_ERR_W
) (
    input  logic Clock,
    input  logic reset,
    updown_count_monitor_if.slave bus
);
    localparam int RUN_W = $clog2(LOCK_CNT + 1);
    localparam logic [RUN_W-1:0] RUN_LOCK = RUN_W'(LOCK_CNT);

    mon_state_t       state;
    logic [WIDTH-1:0] prev;
    logic [RUN_W-1:0] run;
    logic             dir_q, locked_q, hold_q, wrap_q, step_err_q;
    logic [ERR_W-1:0] err_q;

    step_t            step;
    logic             step_wrap;
    logic             step_dir;
    logic [RUN_W-1:0] run_inc;

    count_step_classify #(.WIDTH(WIDTH)) u_classify (
        .prev (prev),
        .cur  (bus.q_in),
        .step (step),
        .wrap (step_wrap)
    );

    assign step_dir = (step == STEP_UP);
    assign run_inc  = run + RUN_W'(1);

    always_ff @(posedge Clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            prev       <= '0;
            run        <= '0;
            dir_q      <= 1'b0;
            locked_q   <= 1'b0;
            hold_q     <= 1'b0;
            wrap_q     <= 1'b0;
            step_err_q <= 1'b0;
            err_q      <= '0;
        end else begin
            hold_q     <= 1'b0;
            wrap_q     <= 1'b0;
            step_err_q <= 1'b0;
            if (bus.sample_en) begin
                // prev always follows the bus so a bad jump resyncs instead of cascading
                prev <= bus.q_in;
                case (state)
                    IDLE: state <= ACQUIRE;
                    ACQUIRE: begin
                        case (step)
                            STEP_UP, STEP_DN: begin
                                wrap_q <= step_wrap;
                                if (step_dir == dir_q) begin
                                    run <= run_inc;
                                    if (run_inc == RUN_LOCK) begin
                                        locked_q <= 1'b1;
                                        state    <= LOCKED;
                                    end
                                end else begin
                                    dir_q <= step_dir;
                                    run   <= RUN_W'(1);
                                    if (LOCK_CNT == 1) begin
                                        locked_q <= 1'b1;
                                        state    <= LOCKED;
                                    end
                                end
                            end
                            STEP_HOLD: hold_q <= 1'b1;
                            default: begin
                                step_err_q <= 1'b1;
                                if (err_q != '1) err_q <= err_q + ERR_W'(1);
                                run <= '0;
                            end
                        endcase
                    end
                    LOCKED: begin
                        case (step)
                            STEP_UP, STEP_DN: begin
                                wrap_q <= step_wrap;
                                dir_q  <= step_dir;
                            end
                            STEP_HOLD: hold_q <= 1'b1;
                            default: begin
                                step_err_q <= 1'b1;
                                if (err_q != '1) err_q <= err_q + ERR_W'(1);
                                run      <= '0;
                                locked_q <= 1'b0;
                                state    <= ACQUIRE;
                            end
                        endcase
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.dir       = dir_q;
    assign bus.locked    = locked_q;
    assign bus.hold      = hold_q;
    assign bus.wrap      = wrap_q;
    assign bus.step_err  = step_err_q;
    assign bus.err_count = err_q;
endmodule

// File: doc/updown_count_monitor.md
Name: updown_count_monitor

Overview:
Receive-side companion to the team's 4-bit T-flip-flop up/down counter. The counter generates a count sequence under direction control x; this block reads that sequence back.
- Samples the counter's Q bus and recovers the direction (1 = up, 0 = down, same sense as x).
- Locks once the stepping is consistent, and flags wrap-arounds and illegal jumps.
- Sits beside the counter as an on-chip checker and direction decoder.

Parameters:
WIDTH, 4, width of observed count bus
LOCK_CNT, 3, consecutive same-direction legal steps required to lock (>=1)
ERR_W, 8, width of saturating error counter

Ports:
Clock  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
sample_en  input  1  q_in is valid and sampled this cycle
q_in  input  WIDTH  observed count value
dir  output  1  recovered direction, 1=up 0=down
locked  output  1  direction tracking is locked
hold  output  1  one-cycle pulse: sampled value equals previous sample
wrap  output  1  one-cycle pulse: legal step crossed max<->0 boundary
step_err  output  1  one-cycle pulse: illegal step detected
err_count  output  ERR_W  number of illegal steps, saturating

Behaviour:
- Reset (reset=0, async): state=IDLE, prev=0, run=0, dir=0, locked=0, hold=0, wrap=0, step_err=0, err_count=0.
- All outputs are registered. They reflect the sample taken on the previous rising edge (latency 1).
- sample_en=0: state, prev, run, dir and locked hold; hold, wrap and step_err are 0 next cycle.
- Step classification, with d = (q_in - prev) mod 2^WIDTH:
  - d==1 -> UP
  - d==2^WIDTH-1 -> DOWN
  - d==0 -> HOLD
  - anything else -> BAD
- prev <= q_in on every sample, including BAD samples (resync to the new value).
- IDLE:
  - First sample only captures prev and moves to ACQUIRE.
  - No pulses; dir and locked are unchanged.
- ACQUIRE:
  - UP/DOWN in the same direction as dir: run++, then go to LOCKED with locked<=1 when run+1 == LOCK_CNT.
  - UP/DOWN opposite to dir: dir<=new direction, run<=1. Go to LOCKED at once if LOCK_CNT==1.
  - HOLD: hold pulse; run unchanged.
  - BAD: step_err pulse, err_count++ (saturating), run<=0.
- LOCKED:
  - UP/DOWN: dir<=step direction, which allows a legal direction reversal; stays LOCKED.
  - HOLD: hold pulse; stays LOCKED.
  - BAD: step_err pulse, err_count++, locked<=0, run<=0, go to ACQUIRE.
- Wrap detection:
  - wrap pulses on UP from all-ones to 0, or on DOWN from 0 to all-ones.
  - Applies in ACQUIRE and LOCKED only, never on the IDLE capture sample.
- err_count saturates at 2^ERR_W-1. step_err still pulses when saturated.
- Reset mid-operation clears everything immediately. The first post-reset sample is a capture only and never produces a step.
- run is clog2(LOCK_CNT+1) bits wide and never exceeds LOCK_CNT.

Decomposition:
- Shared package (updown_mon_pkg):
  - state enum IDLE/ACQUIRE/LOCKED
  - step-class enum STEP_UP/STEP_DN/STEP_HOLD/STEP_BAD
  - defaults for WIDTH and LOCK_CNT
- Sub-module count_step_classify: combinational, (prev, q_in) -> step class plus wrap flag. It is reusable by other checkers.
- The top level holds the FSM, prev/run registers and output registers.

Test Plan:
- Reset, then samples 3,4,5,6 (LOCK_CNT=3) -> locked=1 and dir=1 in the cycle after sample 6; no pulses.
- Locked up, samples 14,15,0,1 -> wrap=1 for exactly the cycle after sample 0; dir stays 1; locked stays 1.
- Locked up at 2, samples 1,0,15 -> dir=0 after sample 1; locked stays 1; wrap pulse after sample 15.
- Locked, jump 5->9, then 10,11,12 -> step_err pulse and err_count=1 after 9, locked=0; locked=1 again after 12.
- Samples 7,7,7 in ACQUIRE -> hold pulses twice; run unchanged; sample_en=0 gaps produce no pulses.
- ERR_W=2 with five BAD steps -> err_count stops at 3. Then reset pulled low mid-LOCKED -> all outputs 0 without waiting for a clock edge.
